iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
Multi-cycle radix-2 restoring divider that serves the EX stage's DIV/DIVU requests, the responder side of the EX divide handshake. It accepts operands with `start`, iterates one quotient bit per clock, and returns {remainder, quotient} with `done`. It holds the result stable until EX acknowledges it with `accept`. It sits inside the divide wrapper instantiated by EX; EX stalls the pipeline while `start` is high and `done` is low.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH ({hi=remainder, lo=quotient}).
ITER_CNT_W, 5, width of the iteration counter (log2 WIDTH).

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  level request; sampled only in IDLE
flag_unsigned  in  1  1 = DIVU, 0 = DIV (two's complement)
operand1  in  WIDTH  dividend (rs)
operand2  in  WIDTH  divisor (rt)
accept  in  1  consumer has taken the result; pulses for one cycle while done=1
cancel  in  1  flush (exception or branch annul); aborts any operation
result  out  2*WIDTH  {remainder, quotient}, registered
done  out  1  result valid, registered
busy  out  1  high in BUSY state

Behaviour:
- Reset is the only mechanism, synchronous, active-high on clk: state=IDLE, result=0, done=0, busy=0, counter=0, and the internal dividend/divisor/partial-remainder registers are 0. Reset overrides every other input in the same cycle.
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - On start=1 and cancel=0, latch the magnitudes.
    - Signed mode: |operand| for each operand.
    - Unsigned mode: raw operands.
  - Latch the quotient sign (op1[31]^op2[31]) and the remainder sign (op1[31]), both forced to 0 in unsigned mode.
  - Clear the partial remainder and set counter=0.
  - If the divisor is 0, go to DONE directly and load result = {operand1, 32'hFFFFFFFF}. This is the fixed div-by-zero response; no sign correction is applied.
  - Otherwise go to BUSY.
- BUSY, one step per cycle:
  - Shift {partial remainder, dividend} left by 1 and trial-subtract the divisor.
  - If the difference is ≥0, keep it and shift in quotient bit 1; otherwise shift in 0.
  - counter increments each step.
  - On the step where counter==WIDTH-1, apply sign correction:
    - quotient negated if its sign bit is set;
    - remainder negated if its sign bit is set.
  - Write result, set done=1, and go to DONE.
- Latency: done is high exactly 32 clock edges after the edge that sampled start (nonzero divisor). With a zero divisor it is 1 edge.
- DONE:
  - done=1 and result are held stable regardless of start or the operands.
  - accept=1 clears done and moves to IDLE.
  - The next start is sampled no earlier than the following cycle, so a start held high through accept cannot re-fire in the same cycle.
  - Back-to-back divides therefore take ≥1 IDLE cycle between operations.
- Result semantics:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend (MIPS).
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, wrapping naturally from the 32-bit magnitude math. No overflow flag.
- cancel=1 in any state: next state IDLE, done=0, busy=0, result unchanged. cancel takes priority over start and accept in the same cycle.
- Operand changes during BUSY have no effect because the operands are latched in IDLE.
- busy = (state==BUSY); done = (state==DONE), registered.
- A reset asserted mid-BUSY forces IDLE on the next edge with every output zeroed.

Decomposition:
- Constants belong in the shared defines header:
  - state encodings DIV_IDLE=2'b00, DIV_BUSY=2'b01, DIV_DONE=2'b10;
  - DIV_WIDTH=32;
  - the div-by-zero quotient constant 32'hFFFFFFFF.
- One natural sub-module, div_step: purely combinational. Inputs are partial remainder, dividend MSB and divisor; outputs are the next partial remainder and the quotient bit. It is instantiated once in iter_divider.

Test Plan:
- Unsigned basic: start, DIVU, op1=100, op2=7 → done 32 edges later, result={32'd2, 32'd14}; result and done stay stable until accept, and done falls the cycle after accept.
- Signed mixed signs: DIV, op1=-7 (0xFFFFFFF9), op2=2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Repeat with op1=7, op2=-2 → quotient -3, remainder +1.
- Boundaries:
  - DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
  - DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
  - DIVU 5 / 0xFFFFFFFF → {5, 0}.
- Divide by zero: DIV op1=0x12345678, op2=0 → done after 1 edge, result={0x12345678, 0xFFFFFFFF}.
- Cancel mid-op:
  - Assert cancel at iteration 10 → IDLE next cycle, done never rises, result keeps its prior value.
  - A new start after that completes correctly with 32-edge latency.
- Handshake and reset:
  - start held high across accept → no restart in the accept cycle; the new op starts on the next IDLE sample.
  - rst pulsed during BUSY → result=0, done=0, busy=0 next edge.

Source files
------------

// File: rtl/iter_divider_pkg.sv
// Shared constants and state encoding for the iterative divider.
package iter_divider_pkg;

  localparam int DIV_WIDTH      = 32;
  localparam int DIV_ITER_CNT_W = 5;

  // Fixed quotient returned when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/iter_divider_if.sv
// EX <-> divider handshake bundle. Prefixes are from the divider's viewpoint.
interface iter_divider_if
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic               i_start;
  logic               i_flag_unsigned;
  logic [WIDTH-1:0]   i_operand1;
  logic [WIDTH-1:0]   i_operand2;
  logic               i_accept;
  logic               i_cancel;
  logic [2*WIDTH-1:0] o_result;
  logic               o_done;
  logic               o_busy;

  // EX stage side
  modport master (
    output i_start, i_flag_unsigned, i_operand1, i_operand2, i_accept, i_cancel,
    input  o_result, o_done, o_busy
  );

  // Divider side
  modport slave (
    input  i_start, i_flag_unsigned, i_operand1, i_operand2, i_accept, i_cancel,
    output o_result, o_done, o_busy
  );

endinterface

// File: rtl/iter_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  // The partial remainder is always below the divisor, so the shifted value
  // is below 2*divisor and the difference fits WIDTH+1 bits; its top bit is
  // therefore a reliable borrow.
  assign w_shifted = {i_rem, i_dvd_msb};
  assign w_diff    = w_shifted - {1'b0, i_divisor};
  assign o_q_bit   = ~w_diff[WIDTH];
  assign o_rem     = o_q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring divider: one quotient bit per clock, {remainder, quotient}
// held with done until accepted; cancel aborts from any state.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH      = DIV_WIDTH,
  parameter int ITER_CNT_W = DIV_ITER_CNT_W
) (
  input logic           clk,
  input logic           rst,
  iter_divider_if.slave bus
);

  localparam logic [ITER_CNT_W-1:0] LAST_ITER = ITER_CNT_W'(WIDTH - 1);

  div_state_e          r_state, w_state_next;
  logic [ITER_CNT_W-1:0] r_cnt, w_cnt_next;
  logic [WIDTH-1:0]    r_dvd, w_dvd_next;    // dividend magnitude, becomes quotient
  logic [WIDTH-1:0]    r_dvs, w_dvs_next;    // divisor magnitude
  logic [WIDTH-1:0]    r_rem, w_rem_next;    // partial remainder
  logic                r_q_sign, w_q_sign_next;
  logic                r_r_sign, w_r_sign_next;
  logic [2*WIDTH-1:0]  r_result, w_result_next;
  logic                r_done;
  logic                r_busy;

  logic [WIDTH-1:0]    w_mag1;
  logic [WIDTH-1:0]    w_mag2;
  logic [WIDTH-1:0]    w_step_rem;
  logic                w_step_q;
  logic [WIDTH-1:0]    w_quot;
  logic [WIDTH-1:0]    w_quot_fix;
  logic [WIDTH-1:0]    w_rem_fix;

  // Signed mode divides magnitudes; the most negative value maps onto itself,
  // which is exactly its unsigned magnitude.
  assign w_mag1 = (!bus.i_flag_unsigned && bus.i_operand1[WIDTH-1]) ? ('0 - bus.i_operand1) : bus.i_operand1;
  assign w_mag2 = (!bus.i_flag_unsigned && bus.i_operand2[WIDTH-1]) ? ('0 - bus.i_operand2) : bus.i_operand2;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_step_rem),
    .o_q_bit   (w_step_q)
  );

  assign w_quot     = {r_dvd[WIDTH-2:0], w_step_q};
  assign w_quot_fix = r_q_sign ? ('0 - w_quot) : w_quot;
  assign w_rem_fix  = r_r_sign ? ('0 - w_step_rem) : w_step_rem;

  // Next-state and datapath-next logic; cancel overrides everything last.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_dvd_next    = r_dvd;
    w_dvs_next    = r_dvs;
    w_rem_next    = r_rem;
    w_q_sign_next = r_q_sign;
    w_r_sign_next = r_r_sign;
    w_result_next = r_result;
    case (r_state)
      DIV_IDLE: begin
        if (bus.i_start && !bus.i_cancel) begin
          w_dvd_next    = w_mag1;
          w_dvs_next    = w_mag2;
          w_q_sign_next = !bus.i_flag_unsigned && (bus.i_operand1[WIDTH-1] ^ bus.i_operand2[WIDTH-1]);
          w_r_sign_next = !bus.i_flag_unsigned && bus.i_operand1[WIDTH-1];
          w_rem_next    = '0;
          w_cnt_next    = '0;
          if (bus.i_operand2 == '0) begin
            w_state_next  = DIV_DONE;
            w_result_next = {bus.i_operand1, WIDTH'(DIV_ZERO_QUOT)};
          end else begin
            w_state_next  = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        w_rem_next = w_step_rem;
        w_dvd_next = w_quot;
        w_cnt_next = r_cnt + ITER_CNT_W'(1);
        if (r_cnt == LAST_ITER) begin
          w_result_next = {w_rem_fix, w_quot_fix};
          w_state_next  = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (bus.i_accept) begin
          w_state_next = DIV_IDLE;
        end
      end
      default: begin
        w_state_next = DIV_IDLE;
      end
    endcase
    if (bus.i_cancel) begin
      w_state_next  = DIV_IDLE;
      w_result_next = r_result;
    end
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_q_sign <= 1'b0;
      r_r_sign <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_dvd    <= w_dvd_next;
      r_dvs    <= w_dvs_next;
      r_rem    <= w_rem_next;
      r_q_sign <= w_q_sign_next;
      r_r_sign <= w_r_sign_next;
      r_result <= w_result_next;
      r_done   <= (w_state_next == DIV_DONE);
      r_busy   <= (w_state_next == DIV_BUSY);
    end
  end

  assign bus.o_result = r_result;
  assign bus.o_done   = r_done;
  assign bus.o_busy   = r_busy;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: driver pushes reference results, the
// monitor pops and compares whenever done rises, and checks result hold.
module tb_iter_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iter_divider_if #(.WIDTH(32)) bus ();

  iter_divider #(.WIDTH(32), .ITER_CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] res;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic        done_prev = 1'b0;
  logic [63:0] hold_val = '0;
  logic [63:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division with 64-bit intermediates.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic uns);
    longint          sq, sr, sa, sb;
    longint unsigned uq, ur, ua, ub;
    logic   [63:0]   q64, r64;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (uns) begin
      ua = longint'(a); ub = longint'(b);
      uq = ua / ub; ur = ua % ub;
      q64 = uq; r64 = ur;
    end else begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      sq = sa / sb; sr = sa % sb;
      q64 = sq; r64 = sr;
    end
    return {r64[31:0], q64[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Monitor: compare on the rising edge of done, then check the held value.
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_done === 1'b1 && done_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: got result %h with no operation outstanding", bus.o_result);
      end else begin
        e = sb_q.pop_front();
        check("result", bus.o_result, e.res);
        check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
        hold_val = e.res;
        $display("op done: result=%h latency=%0d", bus.o_result, cyc - e.start_cyc);
      end
    end else if (bus.o_done === 1'b1) begin
      check("result_hold", bus.o_result, hold_val);
    end
    done_prev = bus.o_done;
  end

  // Present one operation; the next posedge samples it.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic uns, input bit push);
    @(negedge clk);
    bus.i_operand1      = a;
    bus.i_operand2      = b;
    bus.i_flag_unsigned = uns;
    bus.i_start         = 1'b1;
    if (push) begin
      sb_q.push_back('{ref_div(a, b, uns), cyc + 1, (b == 32'd0) ? 0 : 32});
      last_res = ref_div(a, b, uns);
    end
    @(negedge clk);
    bus.i_start         = 1'b0;
    bus.i_operand1      = $urandom;
    bus.i_operand2      = $urandom;
    bus.i_flag_unsigned = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) for done, hold a few cycles with wiggling operands, accept.
  task automatic finish_op();
    int t = 0;
    while (bus.o_done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (bus.o_done !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", bus.o_done, t);
    end
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      bus.i_operand1 = $urandom;
      bus.i_operand2 = $urandom;
    end
    bus.i_accept = 1'b1;
    @(negedge clk);
    bus.i_accept = 1'b0;
    check("done_after_accept", 64'(bus.o_done), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic uns);
    issue(a, b, uns, 1'b1);
    finish_op();
  endtask

  initial begin
    logic [31:0] a, b;
    bit          saw_done;
    bus.i_start = 1'b0; bus.i_flag_unsigned = 1'b0; bus.i_operand1 = '0;
    bus.i_operand2 = '0; bus.i_accept = 1'b0; bus.i_cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", bus.o_result, 64'd0);
    check("reset_done", 64'(bus.o_done), 64'd0);
    check("reset_busy", 64'(bus.o_busy), 64'd0);
    rst = 1'b0;

    // Directed cases
    run_op(32'd100, 32'd7, 1'b1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1);
    run_op(32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op(32'h1234_5678, 32'd0, 1'b0);

    // Cancel at iteration 10: no done, result keeps prior value
    issue(32'd1000, 32'd3, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    bus.i_cancel = 1'b1;
    @(negedge clk);
    bus.i_cancel = 1'b0;
    check("cancel_busy", 64'(bus.o_busy), 64'd0);
    check("cancel_done", 64'(bus.o_done), 64'd0);
    check("cancel_result", bus.o_result, last_res);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) saw_done = 1'b1;
    end
    check("cancel_no_done", 64'(saw_done), 64'd0);
    run_op(32'd1000, 32'd3, 1'b1);

    // Start held high through accept: no re-fire in the accept cycle
    issue(32'd50, 32'd6, 1'b1, 1'b1);
    while (bus.o_done !== 1'b1 && cyc < 5000) @(negedge clk);
    bus.i_operand1 = 32'hFFFF_FF9C; bus.i_operand2 = 32'd9; bus.i_flag_unsigned = 1'b0;
    bus.i_start = 1'b1; bus.i_accept = 1'b1;
    sb_q.push_back('{ref_div(32'hFFFF_FF9C, 32'd9, 1'b0), cyc + 2, 32});
    last_res = ref_div(32'hFFFF_FF9C, 32'd9, 1'b0);
    @(negedge clk);
    bus.i_accept = 1'b0;
    check("held_start_busy", 64'(bus.o_busy), 64'd0);
    check("held_start_done", 64'(bus.o_done), 64'd0);
    @(negedge clk);
    bus.i_start = 1'b0;
    check("held_start_refire", 64'(bus.o_busy), 64'd1);
    finish_op();

    // Reset during BUSY
    issue(32'd12345, 32'd17, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy_result", bus.o_result, 64'd0);
    check("rst_busy_done", 64'(bus.o_done), 64'd0);
    check("rst_busy_busy", 64'(bus.o_busy), 64'd0);
    run_op(32'd12345, 32'd17, 1'b1);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        2: b = 32'd0 - 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
